alu_result_writeback: RTL and testbench
=======================================

// Module: alu_result_writeback
// PURPOSE
//  Downstream of the ALU: queues 16-bit ALU results (Q) with their destination register and
//  writes them into the 32x8 register file through one 8-bit write port. Narrow ops take one
//  write; wide ops (MUL) take two, low byte then high byte into an even/odd register pair.
//  A small FIFO decouples ALU issue from write-port contention (rf_grant).
// PARAMETERS
//  FIFO_DEPTH   2   entries queued; power of two, >=2
//  ADDR_W       5   register-file address width (32 registers)
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       synchronous active-low reset
//  in_valid     in   1       ALU result present this cycle
//  in_ready     out  1       = !full; push occurs on edge when in_valid && in_ready
//  in_result    in   16      ALU Q
//  in_dest      in   ADDR_W  destination register (narrow) / pair base (wide)
//  in_wide      in   1       1 = write both bytes (MUL), 0 = write in_result[7:0] only
//  rf_we        out  1       register-file write strobe (registered)
//  rf_addr      out  ADDR_W  write address (registered)
//  rf_wdata     out  8       write data (registered)
//  rf_grant     in   1       write port available; rf_we write completes on edge with rf_grant=1
//  busy         out  1       FIFO non-empty or write outstanding
//  query_addr   in   ADDR_W  hazard lookup address (used only with WB_HAZARD_EN)
//  query_hit    out  1       pending write targets query_addr (0 without WB_HAZARD_EN)
// BEHAVIOUR
//  - Reset (sync, reset_n=0 at edge): FIFO emptied, FSM->IDLE, rf_we=0, rf_addr=0, rf_wdata=0,
//    in_ready=1 after the edge, busy=0, query_hit=0. Reset mid-write discards queued/in-flight data.
//  - FIFO: rd/wr pointers ADDR bits+1 wrap bit; full when pointers equal except wrap bit.
//    No push when full even if a pop occurs the same edge (in_ready purely !full).
//  - FSM states: IDLE, WR_LO, WR_HI.
//    IDLE: if FIFO non-empty, pop head; load rf_we=1, rf_addr/rf_wdata; ->WR_LO.
//      narrow: addr=dest, data=result[7:0]; wide: addr={dest[4:1],1'b0}, data=result[7:0].
//    WR_LO: rf_grant=0 -> hold all rf_* stable. rf_grant=1 -> if entry wide: load
//      addr={dest[4:1],1'b1}, data=result[15:8], ->WR_HI; else if FIFO non-empty pop next
//      and stay WR_LO (back-to-back, no bubble); else rf_we=0, ->IDLE.
//    WR_HI: rf_grant=0 -> hold. rf_grant=1 -> pop next (->WR_LO) or rf_we=0 ->IDLE.
//  - Wide dest LSB ignored (pair forced even); dest 31 wide -> writes R30,R31; no wrap past 31.
//  - Latency: push at edge N -> rf_we=1 during cycle N+1 when FSM idle (min 1 cycle).
//    Throughput: 1 narrow write/cycle, 1 wide result per 2 cycles with rf_grant held 1.
//  - Push and pop on same edge allowed when not full; count unchanged.
//  - Ordering strictly FIFO; writes never reorder, even when a wide op precedes a narrow op.
//  - busy = FIFO non-empty | rf_we.
// CONFIGURATION
//  WB_HAZARD_EN defined: query_hit combinational = any valid FIFO entry or the in-flight
//    entry whose written register(s) equal query_addr (wide covers both pair regs; for the
//    in-flight wide entry in WR_HI only the odd reg remains). Used by decode to stall RAW.
//  WB_HAZARD_EN undefined: query_hit tied 0, no comparators; query_addr ignored.
// TESTING
//  1. Reset, push narrow {result=16'h00A5,dest=16}, rf_grant=1 -> next cycle rf_we=1,
//     rf_addr=16, rf_wdata=8'hA5; following cycle rf_we=0, busy=0.
//  2. Push wide {result=16'h1234,dest=0} (MUL) -> cycle1 R0<=8'h34, cycle2 R1<=8'h12; dest=5
//     wide -> R4<=lo, R5<=hi.
//  3. rf_grant=0 for 3 cycles during WR_LO of wide entry -> rf_* stable; pushes fill FIFO,
//     in_ready=0 at FIFO_DEPTH entries; on grant all writes emerge in push order.
//  4. Back-to-back narrow pushes R2=8'h11,R3=8'h22,R4=8'h33 every cycle -> three consecutive
//     rf_we cycles, no bubble, in_ready stays 1 (push/pop same edge).
//  5. reset_n=0 while in WR_HI with 2 entries queued -> next cycle rf_we=0, busy=0, in_ready=1;
//     no write of the discarded high byte.
//  6. WB_HAZARD_EN: wide dest=0 queued, query_addr=1 -> query_hit=1; query_addr=2 -> 0;
//     after both writes complete query_addr=1 -> 0. Without macro query_hit always 0.

Source files
------------

// File: rtl/alu_result_writeback.sv
// ALU result writeback: FIFO-buffered 16-bit results written byte-wise into an 8-bit register-file port.
// Optional RAW hazard lookup on pending writes is enabled by defining WB_HAZARD_EN.
module alu_result_writeback #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_result,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wide,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wdata,
  input  logic              rf_grant,
  output logic              busy,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              query_hit
);

  localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_e;

  state_e            state_q;
  logic [15:0]       res_mem_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] dest_mem_q [FIFO_DEPTH];
  logic              wide_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              empty, full, push, pop;
  logic [ADDR_W-1:0] cur_dest_q;
  logic [7:0]        cur_hi_q;
  logic              cur_wide_q;
  logic [15:0]       head_res;
  logic [ADDR_W-1:0] head_dest;
  logic              head_wide;

  assign wr_idx    = wr_ptr_q[IDX_W-1:0];
  assign rd_idx    = rd_ptr_q[IDX_W-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
  assign push      = in_valid && !full;
  assign in_ready  = !full;
  assign busy      = !empty || rf_we;
  assign head_res  = res_mem_q[rd_idx];
  assign head_dest = dest_mem_q[rd_idx];
  assign head_wide = wide_mem_q[rd_idx];

  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = !empty;
      WR_LO:   pop = rf_grant && !cur_wide_q && !empty;
      WR_HI:   pop = rf_grant && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_idx]  <= in_result;
      dest_mem_q[wr_idx] <= in_dest;
      wide_mem_q[wr_idx] <= in_wide;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // A pop always starts a new low-byte write, so it takes priority over the per-state
  // completion handling; the remaining cases only cover granted writes with nothing to pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      cur_dest_q <= '0;
      cur_hi_q   <= '0;
      cur_wide_q <= 1'b0;
    end else if (pop) begin
      state_q    <= WR_LO;
      rf_we      <= 1'b1;
      rf_addr    <= head_wide ? {head_dest[ADDR_W-1:1], 1'b0} : head_dest;
      rf_wdata   <= head_res[7:0];
      cur_dest_q <= head_dest;
      cur_hi_q   <= head_res[15:8];
      cur_wide_q <= head_wide;
    end else begin
      case (state_q)
        WR_LO: begin
          if (rf_grant) begin
            if (cur_wide_q) begin
              state_q  <= WR_HI;
              rf_addr  <= {cur_dest_q[ADDR_W-1:1], 1'b1};
              rf_wdata <= cur_hi_q;
            end else begin
              state_q <= IDLE;
              rf_we   <= 1'b0;
            end
          end
        end
        WR_HI: begin
          if (rf_grant) begin
            state_q <= IDLE;
            rf_we   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_HAZARD_EN
  function automatic logic reg_match(input logic [ADDR_W-1:0] d, input logic w,
                                     input logic [ADDR_W-1:0] q);
    return w ? (d[ADDR_W-1:1] == q[ADDR_W-1:1]) : (d == q);
  endfunction

  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic             hit;

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    count = wr_ptr_q - rd_ptr_q;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      idx = rd_idx + IDX_W'(k);
      if ((PTR_W'(k) < count) && reg_match(dest_mem_q[idx], wide_mem_q[idx], query_addr))
        hit = 1'b1;
    end
    case (state_q)
      WR_LO:   if (reg_match(cur_dest_q, cur_wide_q, query_addr)) hit = 1'b1;
      WR_HI:   if (query_addr == {cur_dest_q[ADDR_W-1:1], 1'b1}) hit = 1'b1;
      default: ;
    endcase
  end

  assign query_hit = hit;
`else
  logic unused_hazard_bits;
  assign unused_hazard_bits = ^{query_addr, cur_dest_q[0]};
  assign query_hit = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: vector table, directed corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_alu_result_writeback;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;
`ifdef WB_HAZARD_EN
  localparam logic HAZ = 1'b1;
`else
  localparam logic HAZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, in_valid, in_ready, in_wide, rf_we, rf_grant, busy, query_hit;
  logic [15:0]   in_result;
  logic [AW-1:0] in_dest, rf_addr, query_addr;
  logic [7:0]    rf_wdata;

  alu_result_writeback #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dest(in_dest), .in_wide(in_wide), .rf_we(rf_we),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_grant(rf_grant), .busy(busy),
    .query_addr(query_addr), .query_hit(query_hit)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queued results plus the byte write currently on the port.
  typedef struct { logic [15:0] r; logic [4:0] d; logic w; } ent_t;
  ent_t       mq[$];
  logic       m_cv = 1'b0, m_hh = 1'b0;
  logic [4:0] m_addr, m_hiaddr;
  logic [7:0] m_data, m_hidata;

  task automatic model_edge(input logic rn, input logic v, input logic [15:0] r,
                            input logic [4:0] d, input logic w, input logic g);
    logic acc;
    ent_t e;
    if (!rn) begin
      mq.delete();
      m_cv = 1'b0;
      m_hh = 1'b0;
      return;
    end
    acc = v && (mq.size() < DEPTH);
    if (!m_cv || g) begin
      if (m_cv && m_hh) begin
        m_addr = m_hiaddr;
        m_data = m_hidata;
        m_hh   = 1'b0;
      end else if (mq.size() > 0) begin
        e        = mq.pop_front();
        m_cv     = 1'b1;
        m_addr   = e.w ? (e.d & 5'h1E) : e.d;
        m_data   = e.r[7:0];
        m_hh     = e.w;
        m_hiaddr = e.d | 5'h01;
        m_hidata = e.r[15:8];
      end else begin
        m_cv = 1'b0;
      end
    end
    if (acc) begin
      e.r = r; e.d = d; e.w = w;
      mq.push_back(e);
    end
  endtask

  function automatic logic m_hit(input logic [4:0] q);
    logic h = 1'b0;
    foreach (mq[i])
      if (mq[i].w ? ((mq[i].d | 5'h01) == (q | 5'h01)) : (mq[i].d == q)) h = 1'b1;
    if (m_cv && (q == m_addr || (m_hh && q == m_hiaddr))) h = 1'b1;
    return HAZ & h;
  endfunction

  task automatic step();
    logic rn = reset_n, v = in_valid, w = in_wide, g = rf_grant;
    logic [15:0] r = in_result;
    logic [4:0]  d = in_dest;
    @(posedge clk);
    model_edge(rn, v, r, d, w, g);
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_cv));
    if (m_cv) begin
      chk("rf_addr", 32'(rf_addr), 32'(m_addr));
      chk("rf_wdata", 32'(rf_wdata), 32'(m_data));
    end
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("busy", 32'(busy), 32'(mq.size() != 0 || m_cv));
    chk("query_hit", 32'(query_hit), 32'(m_hit(query_addr)));
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [4:0] d,
                       input logic w, input logic g);
    in_valid = v; in_result = r; in_dest = d; in_wide = w; rf_grant = g;
  endtask

  task automatic qhit(input string nm, input logic [4:0] q, input logic exp);
    query_addr = q;
    #1;
    chk(nm, 32'(query_hit), 32'(exp));
  endtask

  typedef struct {
    logic [15:0] r; logic [4:0] d; logic w;
    logic [4:0] a0; logic [7:0] d0; logic [4:0] a1; logic [7:0] d1;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h00A5, 5'd16, 1'b0, 5'd16, 8'hA5, 5'd0,  8'h00};
    vecs[1] = '{16'h1234, 5'd0,  1'b1, 5'd0,  8'h34, 5'd1,  8'h12};
    vecs[2] = '{16'hABCD, 5'd5,  1'b1, 5'd4,  8'hCD, 5'd5,  8'hAB};
    vecs[3] = '{16'hBEEF, 5'd31, 1'b1, 5'd30, 8'hEF, 5'd31, 8'hBE};
    vecs[4] = '{16'hFF7E, 5'd31, 1'b0, 5'd31, 8'h7E, 5'd0,  8'h00};
    vecs[5] = '{16'h0080, 5'd1,  1'b0, 5'd1,  8'h80, 5'd0,  8'h00};

    reset_n = 1'b0; query_addr = '0;
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
    step(); step();
    chk("reset_addr", 32'(rf_addr), 32'd0);
    chk("reset_wdata", 32'(rf_wdata), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    // Single results with the port always granted.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].r, vecs[i].d, vecs[i].w, 1'b1);
      step();
      drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      step();
      chk("vec_we_lo", 32'(rf_we), 32'd1);
      chk("vec_addr_lo", 32'(rf_addr), 32'(vecs[i].a0));
      chk("vec_data_lo", 32'(rf_wdata), 32'(vecs[i].d0));
      if (vecs[i].w) begin
        step();
        chk("vec_addr_hi", 32'(rf_addr), 32'(vecs[i].a1));
        chk("vec_data_hi", 32'(rf_wdata), 32'(vecs[i].d1));
      end
      step();
      chk("vec_we_done", 32'(rf_we), 32'd0);
      chk("vec_busy_done", 32'(busy), 32'd0);
    end

    // Grant withheld during a wide low-byte write while the FIFO fills.
    drive(1'b1, 16'h5678, 5'd8, 1'b1, 1'b0);  step();
    drive(1'b1, 16'h0011, 5'd9, 1'b0, 1'b0);  step();
    chk("stall_addr", 32'(rf_addr), 32'd8);
    drive(1'b1, 16'h0022, 5'd10, 1'b0, 1'b0); step();
    chk("stall_full", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h0033, 5'd11, 1'b0, 1'b0); step();
    chk("stall_hold_addr", 32'(rf_addr), 32'd8);
    chk("stall_hold_data", 32'(rf_wdata), 32'h78);
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
    step(); chk("drain1", 32'({rf_addr, rf_wdata}), 32'({5'd9, 8'h56}));
    step(); chk("drain2", 32'({rf_addr, rf_wdata}), 32'({5'd9, 8'h11}));
    step(); chk("drain3", 32'({rf_addr, rf_wdata}), 32'({5'd10, 8'h22}));
    step(); chk("drain_end_we", 32'(rf_we), 32'd0);

    // Back-to-back narrow results, no bubble on the write port.
    drive(1'b1, 16'h0011, 5'd2, 1'b0, 1'b1); step();
    drive(1'b1, 16'h0022, 5'd3, 1'b0, 1'b1); step();
    chk("b2b_w1", 32'({rf_we, rf_addr, rf_wdata}), 32'({1'b1, 5'd2, 8'h11}));
    drive(1'b1, 16'h0033, 5'd4, 1'b0, 1'b1); step();
    chk("b2b_w2", 32'({rf_we, rf_addr, rf_wdata}), 32'({1'b1, 5'd3, 8'h22}));
    chk("b2b_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b1); step();
    chk("b2b_w3", 32'({rf_we, rf_addr, rf_wdata}), 32'({1'b1, 5'd4, 8'h33}));
    step();
    chk("b2b_end", 32'(rf_we), 32'd0);

    // Reset while the high byte is on the port and two entries are queued.
    drive(1'b1, 16'hCAFE, 5'd6, 1'b1, 1'b0);  step();
    drive(1'b1, 16'h0001, 5'd12, 1'b0, 1'b0); step();
    drive(1'b1, 16'h0002, 5'd13, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);     step();
    chk("rst_hi_addr", 32'(rf_addr), 32'd7);
    rf_grant = 1'b0; reset_n = 1'b0; step();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1; rf_grant = 1'b1;
    step(); step();
    chk("rst_no_write", 32'(rf_we), 32'd0);

    // Hazard lookup across queued, low-byte and high-byte phases of a wide result.
    drive(1'b1, 16'h1234, 5'd0, 1'b1, 1'b0); step();
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
    qhit("hz_q_odd", 5'd1, HAZ);
    qhit("hz_q_other", 5'd2, 1'b0);
    step();
    qhit("hz_lo_odd", 5'd1, HAZ);
    qhit("hz_lo_even", 5'd0, HAZ);
    rf_grant = 1'b1; step();
    qhit("hz_hi_even", 5'd0, 1'b0);
    qhit("hz_hi_odd", 5'd1, HAZ);
    step();
    qhit("hz_done", 5'd1, 1'b0);

    // Randomized traffic with occasional resets and grant stalls.
    for (int n = 0; n < 400; n++) begin
      reset_n    = ($urandom_range(0, 63) != 0);
      in_valid   = 1'($urandom_range(0, 1));
      in_result  = 16'($urandom);
      in_dest    = 5'($urandom_range(0, 31));
      in_wide    = 1'($urandom_range(0, 1));
      rf_grant   = ($urandom_range(0, 3) != 0);
      query_addr = 5'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
